// File: rtl/card_pkg.sv
// Shared definitions for the card dealing game controller: key codes,
// FSM states, result encodings and the card face decode.
package card_pkg;

    localparam logic [3:0] KEY_START = 4'b1010;
    localparam logic [3:0] KEY_P1    = 4'b0011;
    localparam logic [3:0] KEY_P2    = 4'b0001;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_P1 = 3'd1,
        DRAW_P1 = 3'd2,
        WAIT_P2 = 3'd3,
        DRAW_P2 = 3'd4,
        COMPARE = 3'd5,
        DONE    = 3'd6
    } state_t;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_P1   = 2'b01;
    localparam logic [1:0] RES_P2   = 2'b10;
    localparam logic [1:0] RES_TIE  = 2'b11;

    // Faces 5..7 fold back onto 1..3; the colour bits never reach here.
    function automatic logic [2:0] card_num(input logic [2:0] face);
        logic [2:0] num;
        case (face)
            3'd0:    num = 3'd1;
            3'd1:    num = 3'd2;
            3'd2:    num = 3'd3;
            3'd3:    num = 3'd4;
            3'd4:    num = 3'd5;
            3'd5:    num = 3'd1;
            3'd6:    num = 3'd2;
            3'd7:    num = 3'd3;
            default: num = 3'd1;
        endcase
        return num;
    endfunction

    function automatic logic [1:0] pick_result(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] res;
        if (a > b) begin
            res = RES_P1;
        end else if (b > a) begin
            res = RES_P2;
        end else begin
            res = RES_TIE;
        end
        return res;
    endfunction

endpackage

// File: rtl/card_deal_ctrl_key_edge_det.sv
// Keypad edge detector: a key code acts only in the first cycle it differs
// from the previous cycle's code, and never in the first cycle after reset.
module key_edge_det
    import card_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] keypad_in,
    output logic       start_edge,
    output logic       p1_edge,
    output logic       p2_edge
);

    logic [3:0] key_r;
    logic       armed_r;
    logic       changed_s;

    // Previous key code and post-reset arming flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_r   <= 4'b0000;
            armed_r <= 1'b0;
        end else begin
            key_r   <= keypad_in;
            armed_r <= 1'b1;
        end
    end

    // Decode a fresh key code into one strobe per action.
    always_comb begin
        changed_s  = armed_r && (keypad_in != key_r);
        start_edge = changed_s && (keypad_in == KEY_START);
        p1_edge    = changed_s && (keypad_in == KEY_P1);
        p2_edge    = changed_s && (keypad_in == KEY_P2);
    end

endmodule

// File: rtl/card_deal_ctrl.sv
// Two-player high-card game controller: players draw in turn from an external
// LFSR, each round is scored and the game ends after ROUNDS rounds.
module card_deal_ctrl
    import card_pkg::*;
#(
    parameter int unsigned ROUNDS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] keypad_in,
    input  logic [4:0] rnd,
    output logic       rnd_en,
    output logic       whose,
    output logic [4:0] card1,
    output logic [4:0] card2,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [3:0] round_cnt,
    output logic       round_done,
    output logic [1:0] round_winner,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam logic [3:0] ROUNDS_V = 4'(ROUNDS);

    state_t     state_r;
    logic       start_edge_s;
    logic       p1_edge_s;
    logic       p2_edge_s;
    logic [2:0] num1_s;
    logic [2:0] num2_s;
    logic [1:0] round_res_s;
    logic [1:0] game_res_s;
    logic [3:0] nxt_score1_s;
    logic [3:0] nxt_score2_s;
    logic [3:0] nxt_cnt_s;
    logic       last_round_s;

    key_edge_det u_key_edge_det (
        .clk        (clk),
        .rst        (rst),
        .keypad_in  (keypad_in),
        .start_edge (start_edge_s),
        .p1_edge    (p1_edge_s),
        .p2_edge    (p2_edge_s)
    );

    // Round scoring and end-of-game result, consumed only in COMPARE.
    always_comb begin
        num1_s       = card_num(card1[2:0]);
        num2_s       = card_num(card2[2:0]);
        round_res_s  = pick_result({1'b0, num1_s}, {1'b0, num2_s});
        nxt_score1_s = score1;
        nxt_score2_s = score2;
        if (round_res_s == RES_P1) begin
            nxt_score1_s = score1 + 4'd1;
        end else if (round_res_s == RES_P2) begin
            nxt_score2_s = score2 + 4'd1;
        end else begin
            nxt_score1_s = score1;
            nxt_score2_s = score2;
        end
        nxt_cnt_s    = round_cnt + 4'd1;
        last_round_s = (nxt_cnt_s == ROUNDS_V);
        game_res_s   = pick_result(nxt_score1_s, nxt_score2_s);
    end

    // Game FSM; every output is a register updated on the transition into its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            rnd_en       <= 1'b0;
            whose        <= 1'b0;
            card1        <= 5'd0;
            card2        <= 5'd0;
            score1       <= 4'd0;
            score2       <= 4'd0;
            round_cnt    <= 4'd0;
            round_done   <= 1'b0;
            round_winner <= RES_NONE;
            game_over    <= 1'b0;
            winner       <= RES_NONE;
        end else begin
            round_done <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    if (start_edge_s) begin
                        state_r      <= WAIT_P1;
                        card1        <= 5'd0;
                        card2        <= 5'd0;
                        score1       <= 4'd0;
                        score2       <= 4'd0;
                        round_cnt    <= 4'd0;
                        round_winner <= RES_NONE;
                        game_over    <= 1'b0;
                        winner       <= RES_NONE;
                    end
                end
                WAIT_P1: begin
                    if (p1_edge_s) begin
                        state_r <= DRAW_P1;
                        rnd_en  <= 1'b1;
                    end
                end
                DRAW_P1: begin
                    card1   <= rnd;
                    rnd_en  <= 1'b0;
                    whose   <= 1'b1;
                    state_r <= WAIT_P2;
                end
                WAIT_P2: begin
                    if (p2_edge_s) begin
                        state_r <= DRAW_P2;
                        rnd_en  <= 1'b1;
                    end
                end
                DRAW_P2: begin
                    card2   <= rnd;
                    rnd_en  <= 1'b0;
                    whose   <= 1'b0;
                    state_r <= COMPARE;
                end
                COMPARE: begin
                    score1       <= nxt_score1_s;
                    score2       <= nxt_score2_s;
                    round_winner <= round_res_s;
                    round_cnt    <= nxt_cnt_s;
                    round_done   <= 1'b1;
                    if (last_round_s) begin
                        state_r   <= DONE;
                        game_over <= 1'b1;
                        winner    <= game_res_s;
                    end else begin
                        state_r <= WAIT_P1;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    rnd_en       <= 1'b0;
                    whose        <= 1'b0;
                    card1        <= 5'd0;
                    card2        <= 5'd0;
                    score1       <= 4'd0;
                    score2       <= 4'd0;
                    round_cnt    <= 4'd0;
                    round_winner <= RES_NONE;
                    game_over    <= 1'b0;
                    winner       <= RES_NONE;
                end
            endcase
        end
    end

endmodule

// File: doc/card_deal_ctrl.md
CARD_DEAL_CTRL -- requirements
Module: card_deal_ctrl

Interface
REQ-001 SHALL provide parameter: ROUNDS, 8, rounds per game (legal range 1..15).
REQ-002 SHALL provide port: clk  in  1  single clock; all state updates on posedge.
REQ-003 SHALL provide port: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL provide port: keypad_in  in  4  key code: 4'b1010 start, 4'b0011 P1 draw, 4'b0001 P2 draw; any other code is no key.
REQ-005 SHALL provide port: rnd  in  5  random card code from the LFSR generator; valid in any cycle where rnd_en=1.
REQ-006 SHALL provide port: rnd_en  out  1  one-cycle pulse that advances the LFSR and marks rnd to be captured.
REQ-007 SHALL provide port: whose  out  1  0 = P1 to draw, 1 = P2 to draw.
REQ-008 SHALL provide port: card1, card2  out  5  last raw card code captured for P1 and P2.
REQ-009 SHALL provide port: score1, score2  out  4  rounds won by each player.
REQ-010 SHALL provide port: round_cnt  out  4  completed rounds in the current game.
REQ-011 SHALL provide port: round_done  out  1  one-cycle pulse when a round is scored.
REQ-012 SHALL provide port: round_winner  out  2  result of the last round: 01 P1, 10 P2, 11 tie; held until the next round_done.
REQ-013 SHALL provide port: game_over  out  1  high while in DONE.
REQ-014 SHALL provide port: winner  out  2  00 while a game is in progress; 01 P1, 10 P2, 11 draw while game_over=1.

Function
REQ-015 SHALL register keypad_in each cycle and act on a key code only in the first cycle it differs from the previous cycle's code (key edge); a held key SHALL act exactly once.
REQ-016 SHALL implement the FSM states IDLE, WAIT_P1, DRAW_P1, WAIT_P2, DRAW_P2, COMPARE, DONE.
REQ-017 In IDLE, a start edge SHALL clear score1, score2, round_cnt, round_winner, card1, card2 and go to WAIT_P1.
REQ-018 In WAIT_P1, a P1 edge SHALL go to DRAW_P1; all other edges SHALL be ignored.
REQ-019 In DRAW_P1 (one cycle), rnd_en SHALL be 1 and card1 SHALL capture rnd at the end of that cycle; the FSM then goes to WAIT_P2.
REQ-020 WAIT_P2 and DRAW_P2 SHALL mirror REQ-018 and REQ-019 using the P2 edge and card2; DRAW_P2 then goes to COMPARE.
REQ-021 rnd_en SHALL be a Moore output, high only in DRAW_P1 and DRAW_P2.
REQ-022 whose SHALL be 1 in WAIT_P2 and DRAW_P2, and 0 in every other state.
REQ-023 Card number decode SHALL map rnd[2:0] as 0..4 -> 1..5 and 5..7 -> 1..3; rnd[4:3] (colour) SHALL NOT affect scoring.
REQ-024 In COMPARE (one cycle), the higher decoded number SHALL win and add 1 to that player's score; a tie SHALL add nothing and set round_winner=11.
REQ-025 In COMPARE, the block SHALL pulse round_done, increment round_cnt, and go to DONE if the new round_cnt equals ROUNDS, otherwise to WAIT_P1.
REQ-026 On entry to DONE, winner SHALL be set by comparing score1 and score2 (the larger wins; equal gives 11).
REQ-027 In DONE, a start edge SHALL behave as REQ-017; any other key SHALL be ignored.
REQ-028 A start edge in any state other than IDLE or DONE SHALL be ignored.
REQ-029 Latency: a draw edge sampled in cycle N SHALL give rnd_en in cycle N+1 and the updated card register visible in cycle N+2.
REQ-030 round_cnt and the scores SHALL never wrap, since ROUNDS is 15 or less.

Reset
REQ-031 With rst=1 at a clock edge, the FSM SHALL go to IDLE and all outputs and the registered key SHALL go to 0, including when reset arrives mid-round.
REQ-032 A key held through the deassertion of reset SHALL NOT produce an edge in the first cycle after reset.

Structure
REQ-033 A shared package card_pkg SHALL hold the key-code constants, the FSM state enum, the round_winner/winner encodings and the card-number decode function.
REQ-034 Key-edge detection SHALL be one sub-module, key_edge_det (inputs clk, rst, keypad_in; outputs start_edge, p1_edge, p2_edge).

Verification
REQ-035 Drive rst=1 for 2 cycles with keypad_in=0011 -> IDLE, all outputs 0, and no rnd_en after release.
REQ-036 Start; P1 draw with rnd=00100; P2 draw with rnd=00000 -> card1=00100, card2=00000, round_done pulses once, round_winner=01, score1=1, round_cnt=1.
REQ-037 Tie: P1 rnd=00001 (number 2), P2 rnd=00110 (number 2) -> round_winner=11, scores unchanged, round_cnt increments.
REQ-038 Hold 0011 for 10 cycles in WAIT_P1 -> exactly one rnd_en pulse; a 0001 in WAIT_P1 -> no state change.
REQ-039 With ROUNDS=2 and P1 winning both rounds -> game_over=1, winner=01; then start -> scores, round_cnt and winner return to 0 and state is WAIT_P1.
REQ-040 Assert rst during DRAW_P2 -> IDLE on the next cycle with all outputs 0; card2 is not updated.
